// File: rtl/soc2_mem_arb.sv
// soc2_mem_arb: round-robin two-master arbiter onto the single soc2 memory slave port.
// Optional response timeout enabled by defining SOC2_ARB_TIMEOUT_EN.
module soc2_mem_arb #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            m0_req,
    input  logic            m0_wr,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    output logic            m0_ack,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic            m1_wr,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic            m1_ack,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            s_req,
    output logic            s_wr,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    input  logic            s_ack,
    input  logic            s_rvalid,
    input  logic [DW-1:0]   s_rdata,
    output logic            arb_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    localparam logic [7:0] TO_LIM = 8'(TO_CYCLES);

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              wr_q, wr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wstrb_q, wstrb_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              win, ack, done, tout;
    logic [DW-1:0]     rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        win     = 1'b0;
        ack     = 1'b0;
        done    = 1'b0;
        tout    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // On a tie the master that was not served last wins
                    win     = (m0_req && m1_req) ? ~last_q : m1_req;
                    gnt_d   = win;
                    wr_d    = win ? m1_wr    : m0_wr;
                    addr_d  = win ? m1_addr  : m0_addr;
                    wdata_d = win ? m1_wdata : m0_wdata;
                    wstrb_d = win ? m1_wstrb : m0_wstrb;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (s_ack) begin
                    ack     = 1'b1;
                    cnt_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (s_rvalid) begin
                    done    = 1'b1;
                    last_d  = gnt_q;
                    state_d = IDLE;
`ifdef SOC2_ARB_TIMEOUT_EN
                end else if (cnt_q == TO_LIM) begin
                    tout    = 1'b1;
                    last_d  = gnt_q;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef SOC2_ARB_TIMEOUT_EN
    logic unused_to;
    assign unused_to = ^{TO_LIM, cnt_q};
`endif

    assign rdata     = tout ? DW'(32'hDEAD_BEEF) : s_rdata;
    assign m0_ack    = ack & ~gnt_q;
    assign m1_ack    = ack &  gnt_q;
    assign m0_rvalid = (done | tout) & ~gnt_q;
    assign m1_rvalid = (done | tout) &  gnt_q;
    assign m0_rdata  = m0_rvalid ? rdata : '0;
    assign m1_rdata  = m1_rvalid ? rdata : '0;
    assign arb_err   = tout;
    assign s_req     = (state_q == REQ);
    assign s_wr      = wr_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;
    assign s_wstrb   = wstrb_q;

endmodule

// File: tb/tb_soc2_mem_arb.sv
// tb_soc2_mem_arb: directed vectors for soc2_mem_arb.
// Inputs change and outputs are sampled just after the falling edge.
module tb_soc2_mem_arb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ack, m0_rvalid, m1_ack, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr, s_ack, s_rvalid, arb_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    soc2_mem_arb #(.AW(32), .DW(32), .TO_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ack(s_ack), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .arb_err(arb_err)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic apply_reset;
        tick;
        resetn = 1'b0;
        m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ack = 0; s_rvalid = 0; s_rdata = 0;
        tick;
        tick;
        resetn = 1'b1;
        tick;
    endtask

    task automatic serve(output int who);
        int n;
        who = -1;
        n = 0;
        tick; #1;
        while (!s_req && n < 8) begin
            tick; #1;
            n++;
        end
        check("srv_sreq", s_req, 1);
        s_ack = 1; #1;
        if (m0_ack) who = 0;
        else if (m1_ack) who = 1;
        tick;
        s_ack = 0;
        tick;
        s_rvalid = 1; s_rdata = 32'h1000; #1;
        check("srv_rv", (who == 0) ? m0_rvalid : m1_rvalid, 1);
        tick;
        s_rvalid = 0;
    endtask

    initial begin
        int who;
        logic seen;
        resetn = 1'b0;
        apply_reset;
        #1;
        check("rst_sreq", s_req, 0);
        check("rst_outs", {m0_ack, m0_rvalid, m1_ack, m1_rvalid, s_wr, arb_err}, 0);
        check("rst_saddr", s_addr, 0);

        // 1: m0 read
        tick;
        m0_req = 1; m0_addr = 32'h1c00_0000; #1;
        check("t1_lat", s_req, 0);
        tick; #1;
        check("t1_sreq", s_req, 1);
        check("t1_saddr", s_addr, 32'h1c00_0000);
        check("t1_swr", s_wr, 0);
        s_ack = 1; #1;
        check("t1_ack", {m0_ack, m1_ack}, 2'b10);
        tick;
        s_ack = 0; m0_req = 0; #1;
        check("t1_ack1", {m0_ack, s_req}, 0);
        tick;
        s_rvalid = 1; s_rdata = 32'h0280_0405; #1;
        check("t1_rv", m0_rvalid, 1);
        check("t1_rdata", m0_rdata, 32'h0280_0405);
        check("t1_m1", {m1_ack, m1_rvalid, m1_rdata}, 0);
        tick;
        s_rvalid = 0; #1;
        check("t1_rv_end", {m0_rvalid, m0_rdata}, 0);

        // 2: simultaneous requests alternate
        apply_reset;
        m0_addr = 32'h100; m1_addr = 32'h200;
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 4; i++) begin
            serve(who);
            check("t2_grant", who, i % 2);
        end

        // 3: m1 write
        apply_reset;
        m1_req = 1; m1_wr = 1; m1_addr = 32'h1c00_1000;
        m1_wdata = 32'h5a; m1_wstrb = 4'b0001;
        tick; #1;
        check("t3_sreq", s_req, 1);
        check("t3_swr", s_wr, 1);
        check("t3_saddr", s_addr, 32'h1c00_1000);
        check("t3_swdata", s_wdata, 32'h5a);
        check("t3_swstrb", s_wstrb, 4'b0001);
        s_ack = 1; #1;
        check("t3_ack", {m0_ack, m1_ack}, 2'b01);
        tick;
        s_ack = 0; m1_req = 0;
        tick;
        s_rvalid = 1; s_rdata = 32'h0; #1;
        check("t3_rv", {m0_rvalid, m1_rvalid}, 2'b01);
        check("t3_rdata", m1_rdata, 0);
        tick;
        s_rvalid = 0;

        // 4: delayed s_ack
        apply_reset;
        m0_req = 1; m0_addr = 32'h1c00_0040;
        for (int i = 0; i < 5; i++) begin
            tick; #1;
            check("t4_hold", {s_req, m0_ack, m1_ack}, 3'b100);
            check("t4_addr", s_addr, 32'h1c00_0040);
        end
        tick;
        s_ack = 1; #1;
        check("t4_ack", m0_ack, 1);
        tick;
        s_ack = 0; m0_req = 0;
        tick;
        s_rvalid = 1; #1;
        check("t4_rv", m0_rvalid, 1);
        tick;
        s_rvalid = 0;

        // 5: reset during RESP
        apply_reset;
        m1_req = 1; m1_addr = 32'h300;
        tick;
        s_ack = 1; #1;
        check("t5_ack", m1_ack, 1);
        tick;
        s_ack = 0; m1_req = 0;
        resetn = 0;
        tick;
        s_rvalid = 1; #1;
        check("t5_rv_rst", {m0_rvalid, m1_rvalid, s_req}, 0);
        tick;
        resetn = 1; #1;
        check("t5_rv_late", {m0_rvalid, m1_rvalid}, 0);
        tick;
        s_rvalid = 0;
        m0_req = 1; m1_req = 1; m0_addr = 32'h400; #1;
        check("t5_idle", s_req, 0);
        tick; #1;
        check("t5_sreq", s_req, 1);
        check("t5_saddr", s_addr, 32'h400);
        s_ack = 1; #1;
        check("t5_tie", {m0_ack, m1_ack}, 2'b10);
        tick;
        s_ack = 0; m0_req = 0; m1_req = 0;
        tick;
        s_rvalid = 1; #1;
        check("t5_rv", m0_rvalid, 1);
        tick;
        s_rvalid = 0;

        // 6: slave never answers
        apply_reset;
        m0_req = 1; m0_addr = 32'h500;
        tick;
        s_ack = 1;
        tick;
        s_ack = 0; m0_req = 0; s_rdata = 32'h1234_5678;
        seen = 0;
`ifdef SOC2_ARB_TIMEOUT_EN
        #1;
        seen = m0_rvalid;
        for (int i = 0; i < 15; i++) begin
            tick; #1;
            seen = seen | m0_rvalid | arb_err;
        end
        check("t6_early", seen, 0);
        tick; #1;
        check("t6_to", {m0_rvalid, m1_rvalid, arb_err}, 3'b101);
        check("t6_rdata", m0_rdata, 32'hDEAD_BEEF);
        tick; #1;
        check("t6_to_end", {m0_rvalid, arb_err}, 0);
        s_rvalid = 1; #1;
        check("t6_late", {m0_rvalid, m1_rvalid}, 0);
        tick;
        s_rvalid = 0;
`else
        #1;
        seen = m0_rvalid;
        for (int i = 0; i < 40; i++) begin
            tick; #1;
            seen = seen | m0_rvalid | arb_err | s_req;
        end
        check("t6_stall", seen, 0);
        s_rvalid = 1; #1;
        check("t6_resume", m0_rvalid, 1);
        check("t6_rdata", m0_rdata, 32'h1234_5678);
        check("t6_err", arb_err, 0);
        tick;
        s_rvalid = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
